// File: rtl/delaychain_sequencer.sv
// Delay-chain latency sequencer: clears the chain, launches a 0->1 step and counts cycles to the selected tap.
// Latency: results update one cycle after the step is seen; done pulses two cycles after the last RECORD/ABORT.
// Backpressure: none; start is only accepted in IDLE, and start requests while busy are dropped.
module delaychain_sequencer #(
  parameter int NTAPS      = 9,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4095,
  parameter int SETTLE     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           tap_sel,
  input  logic [3:0]           runs,
  input  logic [NTAPS-1:0]     tap_in,
  output logic                 test_en,
  output logic                 launch,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     lat_last,
  output logic [CNT_W-1:0]     lat_min,
  output logic [CNT_W-1:0]     lat_max,
  output logic [CNT_W+3:0]     lat_sum,
  output logic [4:0]           runs_done
);

  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_RECORD,
    S_ABORT,
    S_FINISH
  } state_t;

  state_t             state, state_next;
  logic [3:0]         sel, sel_next;
  logic [3:0]         runs_cfg, runs_cfg_next;
  logic [CNT_W-1:0]   phase, phase_next;
  logic [SET_W-1:0]   settle, settle_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  logic               test_en_next, launch_next, busy_next, done_next, err_next;
  logic [CNT_W-1:0]   lat_last_next, lat_min_next, lat_max_next;
  logic [CNT_W+3:0]   lat_sum_next;
  logic [4:0]         runs_done_next;

  logic               tap_bit;
  logic               bad_sel;
  logic [CNT_W-1:0]   phase_inc, cnt_inc;
  logic [SET_W-1:0]   settle_inc;
  logic [4:0]         runs_done_inc;

  // The latched index is always in range while busy, so a one-hot mask picks the observed tap.
  assign tap_bit       = |(tap_in & (NTAPS'(1) << sel));
  assign bad_sel       = ({28'd0, tap_sel} >= 32'(NTAPS));
  assign phase_inc     = phase + CNT_W'(1);
  assign cnt_inc       = cnt + CNT_W'(1);
  assign settle_inc    = settle + SET_W'(1);
  assign runs_done_inc = runs_done + 5'd1;

  // Next-state and next-output logic; every output is the registered copy of its *_next value.
  always_comb begin
    state_next     = state;
    sel_next       = sel;
    runs_cfg_next  = runs_cfg;
    phase_next     = phase;
    settle_next    = settle;
    cnt_next       = cnt;
    test_en_next   = test_en;
    launch_next    = launch;
    busy_next      = busy;
    done_next      = 1'b0;
    err_next       = err;
    lat_last_next  = lat_last;
    lat_min_next   = lat_min;
    lat_max_next   = lat_max;
    lat_sum_next   = lat_sum;
    runs_done_next = runs_done;

    case (state)
      S_IDLE: begin
        if (start) begin
          sel_next       = tap_sel;
          runs_cfg_next  = runs;
          err_next       = 1'b0;
          lat_last_next  = '0;
          lat_min_next   = '1;
          lat_max_next   = '0;
          lat_sum_next   = '0;
          runs_done_next = '0;
          if (bad_sel) begin
            // Nonexistent tap: report and finish without touching the chain.
            err_next  = 1'b1;
            done_next = 1'b1;
          end else begin
            state_next   = S_CLEAR;
            busy_next    = 1'b1;
            test_en_next = 1'b1;
            phase_next   = '0;
            settle_next  = '0;
          end
        end
      end

      S_CLEAR: begin
        launch_next = 1'b0;
        phase_next  = phase_inc;
        settle_next = tap_bit ? '0 : settle_inc;
        // A completed settle wins over a timeout landing on the same edge.
        if (!tap_bit && settle_inc == SET_W'(SETTLE)) begin
          state_next  = S_LAUNCH;
          launch_next = 1'b1;
          cnt_next    = '0;
        end else if (phase_inc == CNT_W'(MAX_CYCLES)) begin
          state_next = S_ABORT;
        end
      end

      S_LAUNCH: begin
        if (tap_bit) begin
          // cnt is frozen here and consumed by RECORD.
          state_next = S_RECORD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
            state_next = S_ABORT;
          end
        end
      end

      S_RECORD: begin
        launch_next    = 1'b0;
        lat_last_next  = cnt;
        lat_min_next   = (cnt < lat_min) ? cnt : lat_min;
        lat_max_next   = (cnt > lat_max) ? cnt : lat_max;
        lat_sum_next   = lat_sum + (CNT_W+4)'(cnt);
        runs_done_next = runs_done_inc;
        if (runs_done_inc == ({1'b0, runs_cfg} + 5'd1)) begin
          state_next = S_FINISH;
        end else begin
          state_next  = S_CLEAR;
          phase_next  = '0;
          settle_next = '0;
        end
      end

      S_ABORT: begin
        err_next    = 1'b1;
        launch_next = 1'b0;
        state_next  = S_FINISH;
      end

      S_FINISH: begin
        done_next    = 1'b1;
        busy_next    = 1'b0;
        test_en_next = 1'b0;
        state_next   = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      runs_cfg  <= '0;
      phase     <= '0;
      settle    <= '0;
      cnt       <= '0;
      test_en   <= 1'b0;
      launch    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      lat_last  <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      runs_done <= '0;
    end else begin
      state     <= state_next;
      sel       <= sel_next;
      runs_cfg  <= runs_cfg_next;
      phase     <= phase_next;
      settle    <= settle_next;
      cnt       <= cnt_next;
      test_en   <= test_en_next;
      launch    <= launch_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
      lat_last  <= lat_last_next;
      lat_min   <= lat_min_next;
      lat_max   <= lat_max_next;
      lat_sum   <= lat_sum_next;
      runs_done <= runs_done_next;
    end
  end

endmodule

// File: tb/tb_delaychain_sequencer.sv
// Directed bench for delaychain_sequencer with a shift-register model of the delay chain.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Every wait on the DUT is bounded and an expired bound counts as a mismatch.
module tb_delaychain_sequencer;

  localparam int NTAPS = 9;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [3:0]         tap_sel;
  logic [3:0]         runs;
  logic [NTAPS-1:0]   tap_in;
  logic               test_en, launch, busy, done, err;
  logic [CNT_W-1:0]   lat_last, lat_min, lat_max;
  logic [CNT_W+3:0]   lat_sum;
  logic [4:0]         runs_done;

  // Chain model: mode 0 = fixed delay dly, 1 = stuck 0, 2 = stuck 1, 3 = delay 5/7 alternating per run.
  int                 mode;
  int                 dly;
  logic [15:0]        sh = '0;
  logic               tap_val;

  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 launch_cnt = 0;
  int                 ten_cnt = 0;
  int                 done_cnt = 0;

  delaychain_sequencer #(
    .NTAPS(NTAPS), .CNT_W(CNT_W), .MAX_CYCLES(4095), .SETTLE(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tap_sel(tap_sel), .runs(runs),
    .tap_in(tap_in), .test_en(test_en), .launch(launch), .busy(busy),
    .done(done), .err(err), .lat_last(lat_last), .lat_min(lat_min),
    .lat_max(lat_max), .lat_sum(lat_sum), .runs_done(runs_done)
  );

  always #5 clk = ~clk;

  // Flop chain fed by launch; sh[k-1] is k flops behind launch.
  always @(posedge clk) sh <= {sh[14:0], launch};

  always_comb begin
    tap_val = 1'b0;
    case (mode)
      0: tap_val = (dly == 0) ? launch : sh[dly-1];
      1: tap_val = 1'b0;
      2: tap_val = 1'b1;
      3: tap_val = runs_done[0] ? sh[6] : sh[4];
      default: tap_val = 1'b0;
    endcase
  end

  assign tap_in = {NTAPS{tap_val}};

  // Activity counters used to prove launch/test_en stayed low and done pulsed once.
  always @(negedge clk) begin
    if (launch)  launch_cnt <= launch_cnt + 1;
    if (test_en) ten_cnt    <= ten_cnt + 1;
    if (done)    done_cnt   <= done_cnt + 1;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after start was sampled.
  task automatic do_start(input logic [3:0] sel, input logic [3:0] r);
    tap_sel = sel;
    runs    = r;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    chk_val(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    int d0, lc, tc;

    rst = 1'b1; start = 1'b0; tap_sel = '0; runs = '0; mode = 0; dly = 3;
    repeat (3) @(negedge clk);
    chk_val("rst_busy",    32'(busy),      32'd0);
    chk_val("rst_test_en", 32'(test_en),   32'd0);
    chk_val("rst_launch",  32'(launch),    32'd0);
    chk_val("rst_done",    32'(done),      32'd0);
    chk_val("rst_err",     32'(err),       32'd0);
    chk_val("rst_min",     32'(lat_min),   32'hFFFF);
    chk_val("rst_sum",     32'(lat_sum),   32'd0);
    chk_val("rst_runs",    32'(runs_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three-flop chain, single run; a second start while busy must be ignored.
    mode = 0; dly = 3; d0 = done_cnt;
    do_start(4'd2, 4'd0);
    chk_val("t1_busy",    32'(busy),    32'd1);
    chk_val("t1_test_en", 32'(test_en), 32'd1);
    repeat (3) @(negedge clk);
    do_start(4'd12, 4'd5);
    wait_done("t1_done", 200, cyc);
    chk_val("t1_last", 32'(lat_last),  32'd3);
    chk_val("t1_min",  32'(lat_min),   32'd3);
    chk_val("t1_max",  32'(lat_max),   32'd3);
    chk_val("t1_sum",  32'(lat_sum),   32'd3);
    chk_val("t1_runs", 32'(runs_done), 32'd1);
    chk_val("t1_err",  32'(err),       32'd0);
    chk_val("t1_ten",  32'(test_en),   32'd0);
    chk_val("t1_busy_end", 32'(busy),  32'd0);
    @(negedge clk);
    chk_val("t1_done_pulse", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    chk_val("t1_one_done", 32'(done_cnt - d0), 32'd1);

    // Tap is launch itself: four runs of latency 0.
    mode = 0; dly = 0;
    do_start(4'd5, 4'd3);
    wait_done("t2_done", 400, cyc);
    chk_val("t2_last", 32'(lat_last),  32'd0);
    chk_val("t2_min",  32'(lat_min),   32'd0);
    chk_val("t2_max",  32'(lat_max),   32'd0);
    chk_val("t2_sum",  32'(lat_sum),   32'd0);
    chk_val("t2_runs", 32'(runs_done), 32'd4);
    repeat (2) @(negedge clk);

    // Latency alternating 5,7,5,7 on the highest legal tap.
    mode = 3;
    do_start(4'd8, 4'd3);
    wait_done("t3_done", 600, cyc);
    chk_val("t3_min",  32'(lat_min),   32'd5);
    chk_val("t3_max",  32'(lat_max),   32'd7);
    chk_val("t3_sum",  32'(lat_sum),   32'd24);
    chk_val("t3_last", 32'(lat_last),  32'd7);
    chk_val("t3_runs", 32'(runs_done), 32'd4);
    chk_val("t3_err",  32'(err),       32'd0);
    repeat (2) @(negedge clk);

    // Out-of-range tap selects: error and done on the next cycle, chain untouched.
    mode = 0; dly = 3; lc = launch_cnt; tc = ten_cnt;
    do_start(4'd12, 4'd0);
    chk_val("bad12_done", 32'(done), 32'd1);
    chk_val("bad12_err",  32'(err),  32'd1);
    chk_val("bad12_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk_val("bad12_done_pulse", 32'(done),      32'd0);
    chk_val("bad12_err_hold",   32'(err),       32'd1);
    chk_val("bad12_min",        32'(lat_min),   32'hFFFF);
    chk_val("bad12_runs",       32'(runs_done), 32'd0);
    do_start(4'd9, 4'd0);
    chk_val("bad9_err",  32'(err),  32'd1);
    chk_val("bad9_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk_val("bad_no_launch", 32'(launch_cnt - lc), 32'd0);
    chk_val("bad_no_ten",    32'(ten_cnt - tc),    32'd0);

    // Tap stuck 0: 4 settle edges, 4095 launch edges, ABORT, FINISH -> done 4101 edges after start.
    mode = 1;
    do_start(4'd0, 4'd0);
    chk_val("s0_err_cleared", 32'(err), 32'd0);
    wait_done("s0_done", 5000, cyc);
    chk_val("s0_cycles", 32'(cyc),       32'd4101);
    chk_val("s0_err",    32'(err),       32'd1);
    chk_val("s0_runs",   32'(runs_done), 32'd0);
    chk_val("s0_min",    32'(lat_min),   32'hFFFF);
    chk_val("s0_sum",    32'(lat_sum),   32'd0);
    repeat (2) @(negedge clk);

    // Tap stuck 1: CLEAR times out after 4095 edges, launch never rises.
    mode = 2; lc = launch_cnt;
    do_start(4'd1, 4'd0);
    wait_done("s1_done", 5000, cyc);
    chk_val("s1_cycles",    32'(cyc),              32'd4097);
    chk_val("s1_err",       32'(err),              32'd1);
    chk_val("s1_no_launch", 32'(launch_cnt - lc),  32'd0);
    repeat (2) @(negedge clk);

    // Reset during the second run's LAUNCH phase.
    mode = 0; dly = 7;
    do_start(4'd3, 4'd1);
    cyc = 0;
    while (!(runs_done == 5'd1 && launch) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk_val("rl_reached", 32'(runs_done == 5'd1 && launch), 32'd1);
    chk_val("rl_pre_last", 32'(lat_last), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk_val("rl_launch",  32'(launch),    32'd0);
    chk_val("rl_test_en", 32'(test_en),   32'd0);
    chk_val("rl_busy",    32'(busy),      32'd0);
    chk_val("rl_last",    32'(lat_last),  32'd0);
    chk_val("rl_min",     32'(lat_min),   32'hFFFF);
    chk_val("rl_max",     32'(lat_max),   32'd0);
    chk_val("rl_runs",    32'(runs_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fresh sequence after reset measures normally.
    dly = 3;
    do_start(4'd4, 4'd1);
    chk_val("pr_busy", 32'(busy), 32'd1);
    wait_done("pr_done", 400, cyc);
    chk_val("pr_runs", 32'(runs_done), 32'd2);
    chk_val("pr_sum",  32'(lat_sum),   32'd6);
    chk_val("pr_min",  32'(lat_min),   32'd3);
    chk_val("pr_max",  32'(lat_max),   32'd3);
    chk_val("pr_err",  32'(err),       32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
